// File: rtl/step_counter.sv
// Stepping counter with runtime step and bounds; wrap, bounce and one-shot modes,
// synchronous load and a registered terminal-count pulse.
module step_counter #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] count,
  output logic             dir_out,
  output logic             tc,
  output logic             done
);

  typedef enum logic [1:0] {
    MODE_WRAP     = 2'b00,
    MODE_BOUNCE   = 2'b01,
    MODE_ONESHOT  = 2'b10,
    MODE_WRAP_ALT = 2'b11
  } mode_e;

  logic [WIDTH-1:0] r_count;
  logic             r_dir;
  logic             r_tc;
  logic             r_done;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic             w_up_bnd;
  logic             w_dn_bnd;
  logic             w_bnd;
  mode_e            w_mode;
  logic [WIDTH-1:0] w_next_count;
  logic             w_next_dir;
  logic             w_next_tc;
  logic             w_next_done;

  assign w_mode = mode_e'(mode);

  // One extra bit keeps the carry of the sum and the borrow of the difference.
  assign w_sum    = {1'b0, r_count} + {1'b0, step};
  assign w_diff   = {1'b0, r_count} - {1'b0, step};
  assign w_up_bnd = w_sum > {1'b0, hi};
  assign w_dn_bnd = w_diff[WIDTH] || (w_diff[WIDTH-1:0] < lo);
  assign w_bnd    = (step != '0) && (r_dir ? w_dn_bnd : w_up_bnd);

  always_comb begin
    w_next_count = r_count;
    w_next_dir   = r_dir;
    w_next_tc    = 1'b0;
    w_next_done  = r_done;
    if (load) begin
      w_next_count = load_val;
      w_next_dir   = dir;
      w_next_done  = 1'b0;
    end else if (en && !r_done && (step != '0)) begin
      if (!w_bnd) begin
        w_next_count = r_dir ? w_diff[WIDTH-1:0] : w_sum[WIDTH-1:0];
      end else begin
        w_next_tc = 1'b1;
        unique case (w_mode)
          MODE_BOUNCE: begin
            w_next_dir = ~r_dir;
            // Reverse by one step, clamped to the bound on the far side.
            if (!r_dir)
              w_next_count = w_dn_bnd ? lo : w_diff[WIDTH-1:0];
            else
              w_next_count = w_up_bnd ? hi : w_sum[WIDTH-1:0];
          end
          MODE_ONESHOT: w_next_done = 1'b1;
          default:      w_next_count = r_dir ? hi : lo;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= RESET_VAL;
      r_dir   <= 1'b0;
      r_tc    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_count <= w_next_count;
      r_dir   <= w_next_dir;
      r_tc    <= w_next_tc;
      r_done  <= w_next_done;
    end
  end

  assign count   = r_count;
  assign dir_out = r_dir;
  assign tc      = r_tc;
  assign done    = r_done;

endmodule
